// File: rtl/dp_addsub_seq.sv
// Issue/capture stage around a combinational double-precision add/sub unit:
// operand FIFO in front, result/tag/flag register behind, valid/ready on both sides.
module dp_addsub_seq #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [63:0]                in_a,
    input  logic [63:0]                in_b,
    input  logic                       in_op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic [63:0]                au_a,
    output logic [63:0]                au_b,
    output logic                       au_op,
    input  logic [63:0]                au_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_result,
    output logic [TAG_W-1:0]           out_tag,
    output logic [2:0]                 out_flags,
    output logic [2:0]                 sticky_flags,
    input  logic                       flag_clr,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 64 + 64 + 1 + TAG_W;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    fifo_count_q, fifo_count_d;
    logic             out_valid_q, out_valid_d;
    logic [63:0]      out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [2:0]       out_flags_q, out_flags_d;
    logic [2:0]       sticky_q, sticky_d;

    logic             push, pop, out_hs;
    logic [EW-1:0]    head;
    logic [TAG_W-1:0] head_tag;
    logic [2:0]       flags_now;
    logic             res_exp_max, res_mant_zero;

    assign in_ready = (fifo_count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (fifo_count_q != '0) && (!out_valid_q || out_ready);
    assign out_hs   = out_valid_q && out_ready;

    // Head is read combinationally so the unit sees the operands in the issue cycle.
    assign head     = mem[rd_ptr_q];
    assign au_a     = head[EW-1 -: 64];
    assign au_b     = head[EW-65 -: 64];
    assign au_op    = head[TAG_W];
    assign head_tag = head[TAG_W-1:0];

    assign res_exp_max   = (au_result[62:52] == 11'h7FF);
    assign res_mant_zero = (au_result[51:0] == 52'd0);

    // An infinite result only counts as overflow when neither operand was already inf/NaN.
    always_comb begin
        flags_now    = 3'b000;
        flags_now[2] = res_exp_max && !res_mant_zero;
        flags_now[1] = res_exp_max && res_mant_zero &&
                       (au_a[62:52] != 11'h7FF) && (au_b[62:52] != 11'h7FF);
        flags_now[0] = (au_result[62:0] == 63'd0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_a, in_b, in_op, in_tag};
        end
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_flags_d  = out_flags_q;
        sticky_d     = sticky_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + AW'(1);
            out_valid_d  = 1'b1;
            out_result_d = au_result;
            out_tag_d    = head_tag;
            out_flags_d  = flags_now;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CW'(1);
            2'b01:   fifo_count_d = fifo_count_q - CW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        // Flags of a handshake coinciding with a clear are kept.
        if (out_hs) begin
            sticky_d = (flag_clr ? 3'b000 : sticky_q) | out_flags_q;
        end else if (flag_clr) begin
            sticky_d = 3'b000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_flags_q  <= '0;
            sticky_q     <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
            out_flags_q  <= out_flags_d;
            sticky_q     <= sticky_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_tag      = out_tag_q;
    assign out_flags    = out_flags_q;
    assign sticky_flags = sticky_q;
    assign fifo_count   = fifo_count_q;
endmodule

// File: tb/tb_dp_addsub_seq.sv
// Directed bench for dp_addsub_seq; a table-driven stub stands in for the add/sub unit.
module tb_dp_addsub_seq;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    localparam logic [63:0] ONE    = 64'h3FF0000000000000;
    localparam logic [63:0] TWO    = 64'h4000000000000000;
    localparam logic [63:0] THREE  = 64'h4008000000000000;
    localparam logic [63:0] INF    = 64'h7FF0000000000000;
    localparam logic [63:0] QNAN   = 64'h7FF8000000000000;
    localparam logic [63:0] DMAX   = 64'h7FEFFFFFFFFFFFFF;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [63:0]      in_a = '0, in_b = '0;
    logic             in_op = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [63:0]      au_a, au_b, au_result;
    logic             au_op;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [63:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       out_flags, sticky_flags;
    logic             flag_clr = 1'b0;
    logic [2:0]       fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dp_addsub_seq #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .au_a(au_a), .au_b(au_b), .au_op(au_op), .au_result(au_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_flags(out_flags),
        .sticky_flags(sticky_flags), .flag_clr(flag_clr), .fifo_count(fifo_count)
    );

    // Stub add/sub unit: known answers for the vectors used here.
    always_comb begin
        au_result = au_a;
        if (au_a == ONE && au_b == TWO && !au_op)       au_result = THREE;
        else if (au_a == INF && au_b == INF && au_op)   au_result = QNAN;
        else if (au_a == DMAX && au_b == DMAX && !au_op) au_result = INF;
        else if (au_a == INF && au_b == ONE && !au_op)  au_result = INF;
        else if (au_a == ONE && au_b == ONE && au_op)   au_result = 64'd0;
        else if (au_a == ONE && au_b == ONE && !au_op)  au_result = TWO;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request with out_ready=1: result checked after the second edge, sticky after the handshake.
    task automatic run_one(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic op, input logic [TAG_W-1:0] tag,
                           input logic [63:0] exp_res, input logic [2:0] exp_flags,
                           input logic [2:0] exp_sticky, input logic clr_at_hs);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_tag = tag;
        tick();
        in_valid = 1'b0;
        check_eq({name, " valid_early"}, {63'd0, out_valid}, 64'd0);
        tick();
        check_eq({name, " valid"},  {63'd0, out_valid}, 64'd1);
        check_eq({name, " result"}, out_result, exp_res);
        check_eq({name, " tag"},    {60'd0, out_tag}, {60'd0, tag});
        check_eq({name, " flags"},  {61'd0, out_flags}, {61'd0, exp_flags});
        flag_clr = clr_at_hs;
        tick();
        flag_clr = 1'b0;
        check_eq({name, " sticky"}, {61'd0, sticky_flags}, {61'd0, exp_sticky});
        check_eq({name, " drained"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int accepted;
        #12;
        check_eq("rst out_valid",  {63'd0, out_valid}, 64'd0);
        check_eq("rst in_ready",   {63'd0, in_ready}, 64'd1);
        check_eq("rst fifo_count", {61'd0, fifo_count}, 64'd0);
        check_eq("rst out_result", out_result, 64'd0);
        check_eq("rst sticky",     {61'd0, sticky_flags}, 64'd0);
        rst = 1'b0;
        tick();

        run_one("add",     ONE,  TWO,  1'b0, 4'd3, THREE,  3'b000, 3'b000, 1'b0);
        run_one("inf-inf", INF,  INF,  1'b1, 4'd5, QNAN,   3'b100, 3'b100, 1'b0);
        run_one("ovf",     DMAX, DMAX, 1'b0, 4'd6, INF,    3'b010, 3'b110, 1'b0);
        run_one("inf+1",   INF,  ONE,  1'b0, 4'd7, INF,    3'b000, 3'b110, 1'b0);
        run_one("zero",    ONE,  ONE,  1'b1, 4'd9, 64'd0,  3'b001, 3'b111, 1'b0);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        check_eq("clr alone sticky", {61'd0, sticky_flags}, 64'd0);
        run_one("inf-inf2", INF, INF,  1'b1, 4'd10, QNAN,  3'b100, 3'b100, 1'b0);
        run_one("zero+clr", ONE, ONE,  1'b1, 4'd11, 64'd0, 3'b001, 3'b001, 1'b1);

        // Backpressure: offer tags 0..7 with the consumer stalled.
        out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_a = ONE; in_b = ONE; in_op = 1'b0; in_tag = TAG_W'(i);
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        check_eq("bp accepted",   accepted, 64'd5);
        check_eq("bp in_ready",   {63'd0, in_ready}, 64'd0);
        check_eq("bp fifo_count", {61'd0, fifo_count}, 64'd4);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("bp valid%0d", k), {63'd0, out_valid}, 64'd1);
            check_eq($sformatf("bp tag%0d", k),   {60'd0, out_tag}, 64'(k));
            check_eq($sformatf("bp res%0d", k),   out_result, TWO);
            tick();
        end
        check_eq("bp empty valid", {63'd0, out_valid}, 64'd0);
        check_eq("bp empty count", {61'd0, fifo_count}, 64'd0);

        // Reset mid-stream with one result held and three queued.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = ONE; in_b = TWO; in_op = 1'b0; in_tag = TAG_W'(8 + i);
            tick();
        end
        in_valid = 1'b0;
        check_eq("pre-rst count", {61'd0, fifo_count}, 64'd3);
        check_eq("pre-rst valid", {63'd0, out_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid-rst valid",    {63'd0, out_valid}, 64'd0);
        check_eq("mid-rst count",    {61'd0, fifo_count}, 64'd0);
        check_eq("mid-rst in_ready", {63'd0, in_ready}, 64'd1);
        check_eq("mid-rst tag",      {60'd0, out_tag}, 64'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        run_one("post-rst", ONE, TWO, 1'b0, 4'd12, THREE, 3'b000, 3'b000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, expected finish");
        $fatal(1);
    end
endmodule
